// File: rtl/pid_suma_sat_if.sv
// Bundle between the P/I/D multiplier strobes and the saturated control-word output.
interface pid_suma_sat_if #(
  parameter int cant_bits = 13
);
  logic signed [2*cant_bits-1:0] R_Mul_P;
  logic signed [2*cant_bits-1:0] R_Mul_I;
  logic signed [2*cant_bits-1:0] R_Mul_D;
  logic                          En_P;
  logic                          En_I;
  logic                          En_D;
  logic signed [cant_bits-1:0]   U;
  logic                          U_Valid;
  logic                          Sat;
  logic                          Err;

  modport master (
    output R_Mul_P, R_Mul_I, R_Mul_D, En_P, En_I, En_D,
    input  U, U_Valid, Sat, Err
  );

  modport slave (
    input  R_Mul_P, R_Mul_I, R_Mul_D, En_P, En_I, En_D,
    output U, U_Valid, Sat, Err
  );
endinterface

// File: rtl/pid_suma_sat.sv
// Collects P/I/D products, rescales to Q(N,F), sums and saturates into U.
// Optional frame timeout: define PID_SUMA_TIMEOUT_EN.
module pid_suma_sat #(
  parameter int cant_bits = 13,
  parameter int frac_bits = 6,
  parameter int timeout   = 32
) (
  input logic           Clk_G,
  input logic           Rst_G,
  pid_suma_sat_if.slave bus
);
  localparam int PW = 2 * cant_bits;
  localparam int TW = PW - frac_bits;
  localparam int SW = TW + 2;
  localparam logic signed [SW-1:0] MAXV = {{(SW-cant_bits+1){1'b0}}, {(cant_bits-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-cant_bits+1){1'b1}}, {(cant_bits-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COLLECT, SUM, SAT} state_t;
  state_t state, state_nx;

  logic [2:0]             en;
  logic [2:0]             flags;
  logic [2:0]             cap;
  logic                   all_set;
  logic                   expire;
  logic                   clr_flags;
  logic                   load_sum;
  logic                   load_u;
  logic signed [PW-1:0]   p_q, i_q, d_q;
  logic signed [SW-1:0]   p_e, i_e, d_e;
  logic signed [SW-1:0]   s_q;
  logic signed [cant_bits-1:0] u_d;
  logic                   sat_d;
  logic                   unused_bits;

  assign en      = {bus.En_D, bus.En_I, bus.En_P};
  assign all_set = &(flags | en);

`ifdef PID_SUMA_TIMEOUT_EN
  localparam int CW = $clog2(timeout + 1);
  logic [CW-1:0] cnt;

  // Held at zero outside COLLECT, so it reads 0 in the first COLLECT cycle.
  always_ff @(posedge Clk_G) begin
    if (Rst_G || state != COLLECT) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  assign expire = (state == COLLECT) && (cnt == CW'(timeout - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign expire         = 1'b0;
`endif

  always_ff @(posedge Clk_G) begin
    if (Rst_G) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|en) state_nx = (&en) ? SUM : COLLECT;
      COLLECT: begin
        if (expire)       state_nx = IDLE;
        else if (all_set) state_nx = SUM;
      end
      SUM:     state_nx = SAT;
      SAT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Expiry wins over a strobe in the same cycle, so that strobe is dropped.
  always_comb begin
    cap       = '0;
    clr_flags = 1'b0;
    load_sum  = 1'b0;
    load_u    = 1'b0;
    unique case (state)
      IDLE:    cap = en;
      COLLECT: begin
        if (expire) clr_flags = 1'b1;
        else        cap       = en;
      end
      SUM: begin
        load_sum  = 1'b1;
        clr_flags = 1'b1;
      end
      SAT:     load_u = 1'b1;
      default: ;
    endcase
  end

  // Dropping the F low bits is the arithmetic shift (floor toward -inf).
  assign p_e = {{(SW-TW){p_q[PW-1]}}, p_q[PW-1:frac_bits]};
  assign i_e = {{(SW-TW){i_q[PW-1]}}, i_q[PW-1:frac_bits]};
  assign d_e = {{(SW-TW){d_q[PW-1]}}, d_q[PW-1:frac_bits]};
  assign unused_bits = ^{p_q[frac_bits-1:0], i_q[frac_bits-1:0], d_q[frac_bits-1:0]};

  always_comb begin
    sat_d = 1'b0;
    u_d   = s_q[cant_bits-1:0];
    if (s_q > MAXV) begin
      u_d   = MAXV[cant_bits-1:0];
      sat_d = 1'b1;
    end else if (s_q < MINV) begin
      u_d   = MINV[cant_bits-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge Clk_G) begin
    if (Rst_G) begin
      flags       <= '0;
      p_q         <= '0;
      i_q         <= '0;
      d_q         <= '0;
      s_q         <= '0;
      bus.U       <= '0;
      bus.Sat     <= 1'b0;
      bus.U_Valid <= 1'b0;
      bus.Err     <= 1'b0;
    end else begin
      flags       <= clr_flags ? '0 : (flags | cap);
      if (cap[0]) p_q <= bus.R_Mul_P;
      if (cap[1]) i_q <= bus.R_Mul_I;
      if (cap[2]) d_q <= bus.R_Mul_D;
      if (load_sum) s_q <= p_e + i_e + d_e;
      if (load_u) begin
        bus.U   <= u_d;
        bus.Sat <= sat_d;
      end
      bus.U_Valid <= load_u;
      bus.Err     <= expire;
    end
  end
endmodule

// File: tb/tb_pid_suma_sat.sv
// Scoreboard bench for pid_suma_sat: driver feeds a floor-divide/clip model, monitor checks outputs.
module tb_pid_suma_sat;
  localparam int N  = 13;
  localparam int F  = 6;
  localparam int TO = 20;

  logic Clk_G = 1'b0;
  logic Rst_G;
  always #5 Clk_G = ~Clk_G;

  pid_suma_sat_if #(.cant_bits(N)) bus ();
  pid_suma_sat #(.cant_bits(N), .frac_bits(F), .timeout(TO)) dut (
    .Clk_G(Clk_G),
    .Rst_G(Rst_G),
    .bus  (bus)
  );

  typedef struct {
    logic signed [N-1:0] u;
    logic                sat;
    int                  cyc;
  } exp_t;

  exp_t   q[$];
  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  int     err_exp = -1;
  int     pushes = 0;
  logic signed [N-1:0] u_hold;
  logic   sat_hold;
  bit     mf[3];
  longint mv[3];
  bit     model_ignore;

  always @(posedge Clk_G) cyc <= cyc + 1;

  function automatic longint floor_div(input longint a);
    longint d;
    longint r;
    d = longint'(1) << F;
    r = a / d;
    if (a < 0 && (a % d) != 0) r = r - 1;
    return r;
  endfunction

  function automatic longint rnd_prod();
    logic [2*N-1:0] r;
    r = (2*N)'($urandom);
    case ($urandom_range(0, 3))
      0:       return longint'($signed(r));
      1:       return longint'($urandom_range(0, 200000)) - 100000;
      default: return longint'($urandom_range(0, 20000)) - 10000;
    endcase
  endfunction

  task automatic push_expected();
    longint s;
    longint hi;
    longint lo;
    exp_t   e;
    hi = (longint'(1) << (N-1)) - 1;
    lo = -(longint'(1) << (N-1));
    s  = floor_div(mv[0]) + floor_div(mv[1]) + floor_div(mv[2]);
    e.sat = (s > hi) || (s < lo);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    e.u   = s[N-1:0];
    e.cyc = cyc + 3;
    q.push_back(e);
    pushes++;
  endtask

  task automatic step(input bit ep, input bit ei, input bit ed,
                      input longint p, input longint i, input longint d);
    @(posedge Clk_G); #1;
    bus.En_P    = ep;
    bus.En_I    = ei;
    bus.En_D    = ed;
    bus.R_Mul_P = ep ? p[2*N-1:0] : (2*N)'($urandom);
    bus.R_Mul_I = ei ? i[2*N-1:0] : (2*N)'($urandom);
    bus.R_Mul_D = ed ? d[2*N-1:0] : (2*N)'($urandom);
    if (!model_ignore) begin
      if (ep) begin mf[0] = 1'b1; mv[0] = p; end
      if (ei) begin mf[1] = 1'b1; mv[1] = i; end
      if (ed) begin mf[2] = 1'b1; mv[2] = d; end
      if (mf[0] && mf[1] && mf[2]) begin
        push_expected();
        mf = '{1'b0, 1'b0, 1'b0};
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((q.size() != 0 || err_exp >= 0) && b < 30) begin
      idle(1);
      b++;
    end
    if (q.size() != 0 || err_exp >= 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d results outstanding, err_pending=%0d, want none", q.size(), err_exp);
      q.delete();
      err_exp = -1;
    end
  endtask

  task automatic check_hold(input string name);
    idle(1);
    @(negedge Clk_G);
    vectors++;
    if (bus.U !== u_hold || bus.Sat !== sat_hold || bus.U_Valid !== 1'b0 || bus.Err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got U=%0d Sat=%b U_Valid=%b Err=%b, want U=%0d Sat=%b U_Valid=0 Err=0",
               name, bus.U, bus.Sat, bus.U_Valid, bus.Err, u_hold, sat_hold);
    end
  endtask

  task automatic do_reset();
    @(posedge Clk_G); #1;
    Rst_G    = 1'b1;
    bus.En_P = 1'b0;
    bus.En_I = 1'b0;
    bus.En_D = 1'b0;
    mf       = '{1'b0, 1'b0, 1'b0};
    u_hold   = '0;
    sat_hold = 1'b0;
    @(posedge Clk_G); #1;
    Rst_G = 1'b0;
  endtask

  always @(negedge Clk_G) begin
    exp_t e;
    if (Rst_G !== 1'b1) begin
      if (bus.U_Valid === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: U_Valid=1 U=%0d at cycle %0d, want U_Valid=0", bus.U, cyc);
        end else begin
          e = q.pop_front();
          if (bus.U !== e.u || bus.Sat !== e.sat || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL result: got U=%0d Sat=%b at cycle %0d, want U=%0d Sat=%b at cycle %0d",
                     bus.U, bus.Sat, cyc, e.u, e.sat, e.cyc);
          end
          u_hold   = e.u;
          sat_hold = e.sat;
        end
      end
      if (bus.Err === 1'b1) begin
        vectors++;
        if (err_exp != cyc) begin
          miscompares++;
          $display("FAIL err_pulse: Err=1 at cycle %0d, want at cycle %0d (-1 = never)", cyc, err_exp);
        end
        err_exp = -1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    Rst_G        = 1'b1;
    bus.En_P     = 1'b0;
    bus.En_I     = 1'b0;
    bus.En_D     = 1'b0;
    bus.R_Mul_P  = '0;
    bus.R_Mul_I  = '0;
    bus.R_Mul_D  = '0;
    model_ignore = 1'b0;
    u_hold       = '0;
    sat_hold     = 1'b0;
    mf           = '{1'b0, 1'b0, 1'b0};
    @(posedge Clk_G); #1;
    Rst_G = 1'b0;
    check_hold("reset_state");

    // Sequential strobes: 64 + 128 - 32
    step(1, 0, 0, 4096, 0, 0);
    step(0, 1, 0, 0, 8192, 0);
    step(0, 0, 1, 0, 0, -2048);
    drain();
    check_hold("hold_after_160");

    // Simultaneous strobes with saturation both ways
    step(1, 1, 1, 300000, 0, 0);
    drain();
    step(1, 1, 1, -300000, 0, 0);
    drain();

    // Clip thresholds
    step(1, 1, 1, 262143, 0, 0);  drain();
    step(1, 1, 1, 262144, 0, 0);  drain();
    step(1, 1, 1, -262144, 0, 0); drain();
    step(1, 1, 1, -262145, 0, 0); drain();
    step(1, 1, 1, 33554431, 33554431, 33554431);    drain();
    step(1, 1, 1, -33554432, -33554432, -33554432); drain();

    // Duplicate strobe, then strobes during SUM and SAT that must be ignored
    step(1, 0, 0, 64, 0, 0);
    step(1, 0, 0, 6400, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    model_ignore = 1'b1;
    step(1, 1, 1, 1000, 1000, 1000);
    step(1, 1, 1, 2000, 2000, 2000);
    model_ignore = 1'b0;
    drain();
    idle(4);
    check_hold("no_extra_valid");

    // Mid-frame reset discards partial captures
    step(1, 0, 0, 5000, 0, 0);
    step(0, 1, 0, 0, 5000, 0);
    do_reset();
    step(0, 0, 1, 0, 0, 640);
    idle(6);
    check_hold("mid_frame_reset");
    step(1, 1, 1, 640, 640, 640);
    drain();

    // Incomplete frame
    step(1, 0, 0, 12800, 0, 0);
    c0 = cyc;
    step(0, 1, 0, 0, -6400, 0);
`ifdef PID_SUMA_TIMEOUT_EN
    while (cyc < c0 + TO - 1) idle(1);
    model_ignore = 1'b1;
    step(0, 0, 1, 0, 0, 640);
    model_ignore = 1'b0;
    mf      = '{1'b0, 1'b0, 1'b0};
    err_exp = c0 + TO + 1;
    drain();
    check_hold("timeout_hold");
`else
    idle(40);
    check_hold("collect_waits");
    step(0, 0, 1, 0, 0, 640);
    drain();
`endif
    step(1, 1, 1, 1280, 1280, -640);
    drain();

    // Randomized frames: random order, duplicates, gaps
    for (int f = 0; f < 150; f++) begin
      int start;
      int len;
      bit ep, ei, ed;
      start = pushes;
      len   = 0;
      while (pushes == start) begin
        ep = 1'($urandom_range(0, 1));
        ei = 1'($urandom_range(0, 1));
        ed = 1'($urandom_range(0, 1));
        len++;
        if (len >= 10) begin
          ep = ep | !mf[0];
          ei = ei | !mf[1];
          ed = ed | !mf[2];
        end
        step(ep, ei, ed, rnd_prod(), rnd_prod(), rnd_prod());
      end
      idle(2);
      if (f % 15 == 14) begin
        drain();
        check_hold("random_hold");
      end
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
